// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] inst;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// rtl/instr_fetch_queue_if.sv - memory, redirect and decode-side signals of the fetch stage
interface instr_fetch_queue_if;
    import fetch_pkg::*;

    logic               mem_req;
    logic [PC_W-1:0]    mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               inst_valid;
    logic [INSTR_W-1:0] inst;
    logic [PC_W-1:0]    inst_pc;
    logic               inst_ready;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word-fall-through queue of fetched {inst, pc} entries
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // A flush drops both the pending push and pop; storage contents are left stale.
        if (flush) begin
            mem_d    = mem_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - decoupled fetch stage: req/ack memory fetch FSM feeding a decode queue
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  stale_addr_q, stale_addr_d;
    logic [PC_W-1:0]  target_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push, pop;
    fetch_entry_t     wr_entry, head;

    always_comb begin
        target_pc    = bus.redirect_pc & ~32'h3;
        pop          = bus.inst_valid && bus.inst_ready;
        push         = (state_q == REQ) && bus.mem_ack && !bus.redirect;
        count_next   = count + CNT_W'(push) - CNT_W'(pop);
        wr_entry     = '{inst: bus.mem_rdata, pc: fetch_pc_q};
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        stale_addr_d = stale_addr_q;

        case (state_q)
            IDLE: begin
                if (!bus.redirect && (count < CNT_W'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    // An unacked request must still be completed, so park its address in DROP.
                    if (bus.mem_ack) begin
                        state_d = IDLE;
                    end else begin
                        stale_addr_d = fetch_pc_q;
                        state_d      = DROP;
                    end
                end else if (bus.mem_ack) begin
                    state_d = (count_next < CNT_W'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.mem_ack) begin
                    state_d = bus.redirect ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = target_pc;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= {RESET_PC[31:2], 2'b00};
            stale_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (bus.redirect),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign bus.mem_req    = (state_q != IDLE);
    assign bus.mem_addr   = (state_q == DROP) ? stale_addr_q : fetch_pc_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] XORK  = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          ack;
        bit          redir;
        logic [31:0] rpc;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: is a fetch wanted, is an abandoned request still owed an ack, and the queue itself.
    bit          m_fetching;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_pc;
    ent_t        mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_fetching   = 1'b0;
        m_stale      = 1'b0;
        m_stale_addr = '0;
        m_pc         = RPC;
        mq.delete();
    endfunction

    function automatic logic [31:0] m_addr();
        return m_stale ? m_stale_addr : m_pc;
    endfunction

    function automatic void model_step(input bit ack, input bit redir, input logic [31:0] rpc,
                                       input bit ready, input logic [31:0] rdata);
        bit pop;
        int sz;
        sz  = mq.size();
        pop = (sz != 0) && ready && !redir;
        if (m_stale) begin
            if (ack) begin
                m_stale    = 1'b0;
                m_fetching = !redir;
            end
            if (pop) void'(mq.pop_front());
        end else if (m_fetching) begin
            if (redir) begin
                if (!ack) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_fetching = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (ack) begin
                    mq.push_back('{inst: rdata, pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
                m_fetching = (mq.size() < DEPTH);
            end
        end else begin
            if (!redir && sz < DEPTH) m_fetching = 1'b1;
            if (pop) void'(mq.pop_front());
        end
        if (redir) begin
            m_pc = {rpc[31:2], 2'b00};
            mq.delete();
        end
    endfunction

    task automatic cyc(input bit ack, input bit redir, input logic [31:0] rpc,
                       input bit ready, input logic [31:0] rdata);
        check("mem_req", bus.mem_req, m_fetching || m_stale);
        check("mem_addr", bus.mem_addr, m_addr());
        check("inst_valid", bus.inst_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("inst", bus.inst, mq[0].inst);
            check("inst_pc", bus.inst_pc, mq[0].pc);
        end
        bus.mem_ack     = ack;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.inst_ready  = ready;
        bus.mem_rdata   = rdata;
        model_step(ack, redir, rpc, ready, rdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc_mem(input bit ack, input bit redir, input logic [31:0] rpc, input bit ready);
        cyc(ack, redir, rpc, ready, m_addr() ^ XORK);
    endtask

    task automatic idle_inputs();
        bus.mem_ack     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        bus.mem_rdata   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        tv[0] = '{1, 0, 32'h0,  1, 0, 32'h0,  0, 32'h0};
        tv[1] = '{1, 0, 32'h0,  1, 1, 32'h0,  0, 32'h0};
        tv[2] = '{1, 0, 32'h0,  1, 1, 32'h4,  1, 32'h0};
        tv[3] = '{1, 0, 32'h0,  1, 1, 32'h8,  1, 32'h4};
        tv[4] = '{1, 1, 32'h43, 1, 1, 32'hC,  1, 32'h8};
        tv[5] = '{0, 0, 32'h0,  1, 0, 32'h40, 0, 32'h0};
        tv[6] = '{1, 0, 32'h0,  1, 1, 32'h40, 0, 32'h0};
        tv[7] = '{1, 0, 32'h0,  0, 1, 32'h44, 1, 32'h40};

        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, RPC);
        check("rst_inst_valid", bus.inst_valid, 1'b0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            check($sformatf("tv%0d_req", i), bus.mem_req, tv[i].e_req);
            check($sformatf("tv%0d_valid", i), bus.inst_valid, tv[i].e_valid);
            if (tv[i].e_req) check($sformatf("tv%0d_addr", i), bus.mem_addr, tv[i].e_addr);
            if (tv[i].e_valid) begin
                check($sformatf("tv%0d_pc", i), bus.inst_pc, tv[i].e_pc);
                check($sformatf("tv%0d_inst", i), bus.inst, tv[i].e_pc ^ XORK);
            end
            bus.mem_ack     = tv[i].ack;
            bus.redirect    = tv[i].redir;
            bus.redirect_pc = tv[i].rpc;
            bus.inst_ready  = tv[i].ready;
            bus.mem_rdata   = tv[i].e_addr ^ XORK;
            @(posedge clk);
            @(negedge clk);
        end

        // Fill with decode stalled, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) cyc_mem(1, 0, 0, 0);
        check("full_req_low", bus.mem_req, 1'b0);
        for (int i = 0; i < 8; i++) cyc_mem(1, 0, 0, 1);

        // Slow memory with a redirect while the request at 8 is outstanding.
        do_reset();
        cyc_mem(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            cyc_mem(0, 0, 0, 0); cyc_mem(0, 0, 0, 0); cyc_mem(1, 0, 0, 0);
        end
        cyc_mem(0, 0, 0, 0);
        cyc_mem(0, 1, 32'h40, 0);
        check("drop_addr", bus.mem_addr, 32'h8);
        cyc_mem(0, 0, 0, 0); cyc_mem(0, 0, 0, 0); cyc_mem(1, 0, 0, 0);
        check("post_drop_addr", bus.mem_addr, 32'h40);
        cyc_mem(0, 0, 0, 0); cyc_mem(0, 0, 0, 0); cyc_mem(1, 0, 0, 0);
        check("first_pc_after_redirect", bus.inst_pc, 32'h40);
        cyc_mem(0, 0, 0, 1); cyc_mem(0, 0, 0, 1);

        // Redirect coinciding with an ack.
        do_reset();
        cyc_mem(1, 0, 0, 1); cyc_mem(1, 0, 0, 1);
        cyc_mem(1, 1, 32'h100, 1);
        check("redir_ack_valid", bus.inst_valid, 1'b0);
        for (int i = 0; i < 3; i++) cyc_mem(1, 0, 0, 1);

        // Asynchronous reset mid-request.
        do_reset();
        for (int i = 0; i < 3; i++) cyc_mem(1, 0, 0, 0);
        cyc_mem(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", bus.mem_req, 1'b0);
        check("async_rst_valid", bus.inst_valid, 1'b0);
        check("async_rst_addr", bus.mem_addr, RPC);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) cyc_mem(1, 0, 0, 1);

        // PC wrap at the top of the address space.
        cyc_mem(1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 5; i++) cyc_mem(1, 0, 0, 1);

        // Randomized traffic against the reference.
        for (int i = 0; i < 800; i++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), $urandom,
                ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
